// File: rtl/fft_out_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 32-point MDC FFT output, ping-pong banked.
// Optional frame counter port enabled by defining FFT_REORDER_FRAMECNT_EN.
`timescale 1ns/1ps

module fft_out_reorder #(
    parameter int N     = 32,
    parameter int LOG2N = 5,
    parameter int DW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_re,
    input  logic [DW-1:0]    in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last,
    output logic             ovf
`ifdef FFT_REORDER_FRAMECNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    logic [2*DW-1:0]  mem [2][N];
    logic [1:0]       bank_full, bank_full_nxt;
    logic [LOG2N-1:0] wr_cnt, rd_cnt;
    logic             wr_bank, rd_bank, drop_frame;
    logic             drop_cur, wr_close, wr_commit, rd_adv, rd_take, rd_close;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        drop_cur  = (wr_cnt == '0) ? bank_full[wr_bank] : drop_frame;
        wr_close  = in_valid && (wr_cnt == LAST);
        wr_commit = wr_close && !drop_cur;
        rd_adv    = !out_valid || out_ready;
        rd_take   = rd_adv && bank_full[rd_bank];
        rd_close  = rd_take && (rd_cnt == LAST);
    end

    // Write and read never touch the same bank in one cycle, so a set and a clear both apply.
    always_comb begin
        bank_full_nxt = bank_full;
        if (rd_close)  bank_full_nxt[rd_bank] = 1'b0;
        if (wr_commit) bank_full_nxt[wr_bank] = 1'b1;
    end

    // NOTE: the sample array is deliberately not reset so it can map onto RAM; bank_full alone
    // says which contents are meaningful.
    always_ff @(posedge clk) begin
        if (in_valid && !drop_cur) mem[wr_bank][bitrev(wr_cnt)] <= {in_re, in_im};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            drop_frame <= 1'b0;
            ovf        <= 1'b0;
        end else if (in_valid) begin
            wr_cnt <= wr_close ? '0 : wr_cnt + 1'b1;
            if (wr_cnt == '0) begin
                drop_frame <= bank_full[wr_bank];
                if (bank_full[wr_bank]) ovf <= 1'b1;
            end
            if (wr_commit) wr_bank <= !wr_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            if (rd_adv) begin
                out_valid <= bank_full[rd_bank];
                if (rd_take) begin
                    {out_re, out_im} <= mem[rd_bank][rd_cnt];
                    out_index        <= rd_cnt;
                    out_last         <= (rd_cnt == LAST);
                    rd_cnt           <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST) rd_bank <= !rd_bank;
                end
            end
        end
    end

`ifdef FFT_REORDER_FRAMECNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                      frame_cnt <= '0;
        else if (out_last && out_valid && out_ready) frame_cnt <= frame_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomized bench for fft_out_reorder: scoreboard of natural-order frames built from the input,
// compared on every output handshake, plus latency, stall, overflow and reset checks.
`timescale 1ns/1ps

module tb_fft_out_reorder;

    localparam int N = 32, LOG2N = 5, DW = 9;

    logic             clk = 1'b0, rst = 1'b1;
    logic             in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0]    in_re = '0, in_im = '0;
    logic             out_valid, out_last, ovf;
    logic [DW-1:0]    out_re, out_im;
    logic [LOG2N-1:0] out_index;
`ifdef FFT_REORDER_FRAMECNT_EN
    logic [7:0]       frame_cnt;
`endif

    fft_out_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_index(out_index), .out_last(out_last), .ovf(ovf)
`ifdef FFT_REORDER_FRAMECNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   re_a[N], im_a[N];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, out_cnt = 0, first_cyc = -1, last_cyc = -1;
    int   ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Position p of an input frame carries bin bitrev(p).
    function automatic int br(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++)
            if ((v >> i) & 1) r += (N / 2) >> i;
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: out_ready = !out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Output monitor: scoreboard on handshakes, hold check while stalled.
    logic          held = 1'b0;
    logic [DW-1:0] h_re, h_im;
    logic [LOG2N-1:0] h_idx;
    logic          h_last;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_re", $signed(out_re), $signed(h_re));
                check("stall_im", $signed(out_im), $signed(h_im));
                check("stall_idx", out_index, h_idx);
                check("stall_last", out_last, h_last);
            end
            if (out_valid && out_ready) begin
                exp_t e;
                out_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                check("expected_output", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_re", $signed(out_re), e.re);
                    check("out_im", $signed(out_im), e.im);
                    check("out_index", out_index, e.idx);
                    check("out_last", out_last, e.last);
                end
            end
            held = out_valid && !out_ready;
            h_re = out_re; h_im = out_im; h_idx = out_index; h_last = out_last;
        end
    end

    task automatic fill_random();
        for (int p = 0; p < N; p++) begin
            re_a[p] = $urandom_range(0, 511) - 256;
            im_a[p] = $urandom_range(0, 511) - 256;
        end
    endtask

    task automatic fill_ramp();
        for (int p = 0; p < N; p++) begin
            re_a[p] = p;
            im_a[p] = -p;
        end
    endtask

    // Called and returns at posedge+1.
    task automatic send_frame(input bit keep, input int gap_pct, input bit chk_ovf, input int cnt);
        for (int p = 0; p < cnt; p++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_re    = DW'(re_a[p]);
            in_im    = DW'(im_a[p]);
            @(posedge clk); #1;
            if (p == 0 && chk_ovf) check("ovf_rise", ovf, 1);
        end
        in_valid = 1'b0;
        if (keep && cnt == N)
            for (int k = 0; k < N; k++)
                exp_q.push_back('{re: re_a[br(k)], im: im_a[br(k)], idx: k, last: (k == N - 1)});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("idle_valid", out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("rst_valid", out_valid, 0);
        check("rst_ovf", ovf, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c0, lat;
        bit found;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();
        check("rst_re", out_re, 0);
        check("rst_im", out_im, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
`ifdef FFT_REORDER_FRAMECNT_EN
        check("rst_frame_cnt", frame_cnt, 0);
`endif

        // 1: ramp frame, latency
        out_ready = 1'b1;
        fill_ramp();
        c0 = cyc;
        send_frame(1, 0, 0, N);
        found = 0; lat = -1;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (out_valid) begin found = 1; lat = cyc - c0; end
        end
        check("latency", lat, 33);
        wait_drain(200);

        // 2: three contiguous frames, no gaps on output
        out_cnt = 0; first_cyc = -1;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            send_frame(1, 0, 0, N);
        end
        wait_drain(300);
        check("t2_count", out_cnt, 96);
        check("t2_contiguous", last_cyc - first_cyc, 95);
        check("t2_ovf", ovf, 0);

        // 3: stalled output, third frame dropped
        out_ready = 1'b0;
        out_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            fill_random();
            send_frame(1, 20, 0, N);
        end
        repeat (3) @(posedge clk);
        #1;
        check("t3_ovf_pre", ovf, 0);
        fill_random();
        send_frame(0, 20, 1, N);
        repeat (5) @(posedge clk);
        #1;
        check("t3_no_accept", out_cnt, 0);
        out_ready = 1'b1;
        wait_drain(400);
        check("t3_count", out_cnt, 64);
        check("t3_ovf_sticky", ovf, 1);

        // 4: toggling ready
        out_cnt = 0;
        ready_mode = 1;
        fill_ramp();
        send_frame(1, 0, 0, N);
        wait_drain(300);
        ready_mode = 0;
        out_ready = 1'b1;
        check("t4_count", out_cnt, 32);

        // 5: reset mid-frame, then a clean frame
        fill_random();
        send_frame(0, 0, 0, 10);
        pulse_reset();
        fill_random();
        send_frame(1, 10, 0, N);
        wait_drain(300);

        // 6: extreme values
        pulse_reset();
        fill_random();
        re_a[1] = -256; im_a[1] = 255;
        re_a[30] = 255; im_a[30] = -256;
        send_frame(1, 0, 0, N);
        wait_drain(200);
`ifdef FFT_REORDER_FRAMECNT_EN
        check("t6_frame_cnt", frame_cnt, 1);
`endif

        // 7: random gaps and random ready, never more than one frame outstanding
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 2000 && exp_q.size() > N; i++) begin
                @(posedge clk); #1;
            end
            check("t7_room", exp_q.size() <= N, 1);
            fill_random();
            send_frame(1, 30, 0, N);
        end
        wait_drain(2000);
        check("t7_ovf", ovf, 0);
        ready_mode = 0;
`ifdef FFT_REORDER_FRAMECNT_EN
        check("t7_frame_cnt", frame_cnt, 7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
